i2c_slave_ctrl: RTL

//  Protocol controller for the I2C slave. Samples SCL/SDA, detects START/STOP,

---
 rtl/i2c_slave_ctrl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: pin synchronisation, START/STOP detection,
// 7-bit address match, write/read byte sequencing with SCL stretching.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       xfer_rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack_det
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        WR_DATA  = 4'd3,
        WR_ACK   = 4'd4,
        RD_LOAD  = 4'd5,
        RD_DATA  = 4'd6,
        RD_ACK   = 4'd7,
        IGNORE   = 4'd8
    } state_t;

    state_t state_r, state_s;

    logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
    logic scl_hist_r, sda_hist_r;
    logic scl_cur_s, sda_cur_s, scl_rise_s, scl_fall_s, start_c_s, stop_c_s;

    logic [7:0] shift_r, shift_s;
    logic [2:0] cnt_r, cnt_s;
    logic full_r, full_s, ack_ok_r, ack_ok_s, rd_nack_r, rd_nack_s;

    logic       sda_oe_s, scl_oe_s, rx_valid_s, tx_ready_s, busy_s, xfer_rw_s;
    logic       start_det_s, stop_det_s, nack_det_s;
    logic [7:0] rx_data_s;

    assign scl_cur_s  = scl_sync_r[SYNC_STAGES-1];
    assign sda_cur_s  = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_cur_s & ~scl_hist_r;
    assign scl_fall_s = ~scl_cur_s & scl_hist_r;
    assign start_c_s  = scl_cur_s & scl_hist_r & sda_hist_r & ~sda_cur_s;
    assign stop_c_s   = scl_cur_s & scl_hist_r & ~sda_hist_r & sda_cur_s;

    // Pin synchronisers plus one history flop; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_hist_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
            scl_hist_r <= scl_cur_s;
            sda_hist_r <= sda_cur_s;
        end
    end

    // Next-state and next-output logic; START/STOP pre-empt every state.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        cnt_s       = cnt_r;
        full_s      = full_r;
        ack_ok_s    = ack_ok_r;
        rd_nack_s   = rd_nack_r;
        sda_oe_s    = sda_oe;
        scl_oe_s    = scl_oe;
        rx_data_s   = rx_data;
        busy_s      = busy;
        xfer_rw_s   = xfer_rw;
        rx_valid_s  = 1'b0;
        tx_ready_s  = 1'b0;
        start_det_s = 1'b0;
        stop_det_s  = 1'b0;
        nack_det_s  = 1'b0;
        if (start_c_s) begin
            state_s     = ADDR;
            cnt_s       = 3'd0;
            full_s      = 1'b0;
            sda_oe_s    = 1'b0;
            scl_oe_s    = 1'b0;
            busy_s      = 1'b0;
            start_det_s = 1'b1;
        end else if (stop_c_s) begin
            state_s    = IDLE;
            cnt_s      = 3'd0;
            full_s     = 1'b0;
            sda_oe_s   = 1'b0;
            scl_oe_s   = 1'b0;
            busy_s     = 1'b0;
            stop_det_s = 1'b1;
        end else begin
            case (state_r)
                IDLE, IGNORE: begin
                    sda_oe_s = 1'b0;
                    scl_oe_s = 1'b0;
                end
                // The SCL fall right after START carries no bit, so a byte
                // completes on the first fall after the 8th rise.
                ADDR, WR_DATA: begin
                    sda_oe_s = 1'b0;
                    scl_oe_s = 1'b0;
                    if (scl_rise_s) begin
                        shift_s = {shift_r[6:0], sda_cur_s};
                        cnt_s   = cnt_r + 3'd1;
                        full_s  = (cnt_r == 3'd7);
                    end else if (scl_fall_s && full_r) begin
                        full_s = 1'b0;
                        if (state_r == ADDR) begin
                            if (shift_r[7:1] == SLV_ADDR) begin
                                state_s   = ADDR_ACK;
                                xfer_rw_s = shift_r[0];
                                busy_s    = 1'b1;
                                sda_oe_s  = 1'b1;
                            end else begin
                                state_s = IGNORE;
                            end
                        end else begin
                            state_s    = WR_ACK;
                            ack_ok_s   = rx_ready;
                            sda_oe_s   = rx_ready;
                            rx_valid_s = rx_ready;
                            if (rx_ready) begin
                                rx_data_s = shift_r;
                            end else begin
                                rx_data_s = rx_data;
                            end
                        end
                    end else begin
                        full_s = full_r;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_s = 1'b0;
                        if (xfer_rw) begin
                            state_s  = RD_LOAD;
                            scl_oe_s = 1'b1;
                        end else begin
                            state_s = WR_DATA;
                        end
                    end else begin
                        state_s = ADDR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_s = 1'b0;
                        state_s  = ack_ok_r ? WR_DATA : IGNORE;
                    end else begin
                        state_s = WR_ACK;
                    end
                end
                // SCL stays held through the load cycle so the first data bit
                // is on SDA one cycle before SCL is released.
                RD_LOAD: begin
                    scl_oe_s = 1'b1;
                    if (tx_valid) begin
                        tx_ready_s = 1'b1;
                        shift_s    = tx_data;
                        sda_oe_s   = ~tx_data[7];
                        cnt_s      = 3'd0;
                        state_s    = RD_DATA;
                    end else begin
                        state_s = RD_LOAD;
                    end
                end
                RD_DATA: begin
                    scl_oe_s = 1'b0;
                    if (scl_fall_s) begin
                        shift_s = {shift_r[6:0], 1'b0};
                        cnt_s   = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            sda_oe_s = 1'b0;
                            state_s  = RD_ACK;
                        end else begin
                            sda_oe_s = ~shift_r[6];
                        end
                    end else begin
                        state_s = RD_DATA;
                    end
                end
                RD_ACK: begin
                    sda_oe_s = 1'b0;
                    scl_oe_s = 1'b0;
                    if (scl_rise_s) begin
                        rd_nack_s = sda_cur_s;
                    end else if (scl_fall_s) begin
                        if (rd_nack_r) begin
                            nack_det_s = 1'b1;
                            state_s    = IGNORE;
                        end else begin
                            scl_oe_s = 1'b1;
                            state_s  = RD_LOAD;
                        end
                    end else begin
                        rd_nack_s = rd_nack_r;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    sda_oe_s = 1'b0;
                    scl_oe_s = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= 8'h00;
            cnt_r     <= 3'd0;
            full_r    <= 1'b0;
            ack_ok_r  <= 1'b0;
            rd_nack_r <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            xfer_rw   <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_det  <= 1'b0;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            cnt_r     <= cnt_s;
            full_r    <= full_s;
            ack_ok_r  <= ack_ok_s;
            rd_nack_r <= rd_nack_s;
            sda_oe    <= sda_oe_s;
            scl_oe    <= scl_oe_s;
            rx_data   <= rx_data_s;
            rx_valid  <= rx_valid_s;
            tx_ready  <= tx_ready_s;
            busy      <= busy_s;
            xfer_rw   <= xfer_rw_s;
            start_det <= start_det_s;
            stop_det  <= stop_det_s;
            nack_det  <= nack_det_s;
        end
    end

endmodule
